// File: rtl/alu_decode.sv
// RV32I ALU-class decode stage: reads the register file, builds the ALU operation and operands,
// and hands them downstream through a valid/ready output register with an optional two-entry skid buffer.
module alu_decode #(
    parameter int SKID_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_alu_op,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal
);

    localparam logic [6:0] ALU_ADD  = 7'd0;
    localparam logic [6:0] ALU_SUB  = 7'd1;
    localparam logic [6:0] ALU_SLL  = 7'd2;
    localparam logic [6:0] ALU_SLT  = 7'd3;
    localparam logic [6:0] ALU_SLTU = 7'd4;
    localparam logic [6:0] ALU_XOR  = 7'd5;
    localparam logic [6:0] ALU_SRL  = 7'd6;
    localparam logic [6:0] ALU_SRA  = 7'd7;
    localparam logic [6:0] ALU_OR   = 7'd8;
    localparam logic [6:0] ALU_AND  = 7'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [6:0]  alu_op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } dec_t;

    localparam dec_t DEC_RESET = '{ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};

    dec_t        dec;
    dec_t        out_q;
    logic        out_valid_q;
    logic        accept;
    logic        legal;
    logic [6:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;

    wire [6:0]  opcode = in_instr[6:0];
    wire [2:0]  funct3 = in_instr[14:12];
    wire [6:0]  funct7 = in_instr[31:25];
    wire [31:0] imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    wire [31:0] imm_u  = {in_instr[31:12], 12'd0};
    wire [31:0] shamt  = {27'd0, in_instr[24:20]};

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign accept   = in_valid & in_ready;

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        op_a  = 32'd0;
        op_b  = 32'd0;
        case (opcode)
            OPC_OP: begin
                op_a = rs1_data;
                op_b = rs2_data;
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  op = ALU_ADD;
                        3'b001:  op = ALU_SLL;
                        3'b010:  op = ALU_SLT;
                        3'b011:  op = ALU_SLTU;
                        3'b100:  op = ALU_XOR;
                        3'b101:  op = ALU_SRL;
                        3'b110:  op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        legal = 1'b1;
                        op    = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        legal = 1'b1;
                        op    = ALU_SRA;
                    end
                end
            end
            OPC_OP_IMM: begin
                op_a  = rs1_data;
                op_b  = imm_i;
                legal = 1'b1;
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        op_b  = shamt;
                        op    = ALU_SLL;
                        legal = (funct7 == 7'b0000000);
                    end
                    default: begin
                        op_b  = shamt;
                        op    = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                op_b  = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op_a  = in_pc;
                op_b  = imm_u;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions collapse to a harmless ADD 0,0 that never writes back.
    always_comb begin
        dec         = DEC_RESET;
        dec.alu_op  = legal ? op : ALU_ADD;
        dec.op1     = legal ? op_a : 32'd0;
        dec.op2     = legal ? op_b : 32'd0;
        dec.rd      = in_instr[11:7];
        dec.rd_we   = legal && (in_instr[11:7] != 5'd0);
        dec.illegal = !legal;
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            dec_t skid_q;
            logic skid_full;
            logic ready_q;

            // The skid entry only fills while the output stalls, so in_ready can be a flop.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_q       <= DEC_RESET;
                    skid_q      <= DEC_RESET;
                    skid_full   <= 1'b0;
                    ready_q     <= 1'b1;
                end else if (!out_valid_q || out_ready) begin
                    if (skid_full) begin
                        out_valid_q <= 1'b1;
                        out_q       <= skid_q;
                        skid_full   <= accept;
                        ready_q     <= !accept;
                        if (accept) begin
                            skid_q <= dec;
                        end
                    end else if (accept) begin
                        out_valid_q <= 1'b1;
                        out_q       <= dec;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end else if (accept) begin
                    skid_q    <= dec;
                    skid_full <= 1'b1;
                    ready_q   <= 1'b0;
                end
            end

            assign in_ready = ready_q;
        end else begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_q       <= DEC_RESET;
                end else if (accept) begin
                    out_valid_q <= 1'b1;
                    out_q       <= dec;
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end

            assign in_ready = !out_valid_q || out_ready;
        end
    endgenerate

    assign out_valid   = out_valid_q;
    assign out_alu_op  = out_q.alu_op;
    assign out_op1     = out_q.op1;
    assign out_op2     = out_q.op2;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
// Directed testbench for alu_decode: decode vectors, skid-buffer backpressure and reset mid-stall.
module tb_alu_decode;

    localparam logic [31:0] ALU_ADD  = 32'd0;
    localparam logic [31:0] ALU_SUB  = 32'd1;
    localparam logic [31:0] ALU_SLL  = 32'd2;
    localparam logic [31:0] ALU_SLT  = 32'd3;
    localparam logic [31:0] ALU_SLTU = 32'd4;
    localparam logic [31:0] ALU_SRA  = 32'd7;
    localparam logic [31:0] ALU_AND  = 32'd9;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_ready;

    logic        in_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        out_valid;
    logic [6:0]  out_alu_op;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    logic        in_ready0;
    logic [4:0]  rs1_addr0;
    logic [4:0]  rs2_addr0;
    logic        out_valid0;
    logic [6:0]  out_alu_op0;
    logic [31:0] out_op10;
    logic [31:0] out_op20;
    logic [4:0]  out_rd0;
    logic        out_rd_we0;
    logic        out_illegal0;

    int n_checks = 0;
    int n_errors = 0;

    alu_decode #(.SKID_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    alu_decode #(.SKID_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr0), .rs2_addr(rs2_addr0),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_alu_op(out_alu_op0), .out_op1(out_op10), .out_op2(out_op20), .out_rd(out_rd0),
        .out_rd_we(out_rd_we0), .out_illegal(out_illegal0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one instruction and waits (bounded) until the skid-mode DUT accepts it.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
        logic was_ready;
        was_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        rs1_data  = r1;
        rs2_data  = r2;
        for (int i = 0; i < 10; i++) begin
            was_ready = in_ready;
            @(posedge clk);
            #1;
            if (was_ready) break;
        end
        in_valid = 1'b0;
        if (!was_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic expectOut(input string tag, input logic [31:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] rd,
                             input logic [31:0] we, input logic [31:0] ill);
        checkOutput({tag, ".valid"},   {31'd0, out_valid}, 32'd1);
        checkOutput({tag, ".alu_op"},  {25'd0, out_alu_op}, op);
        checkOutput({tag, ".op1"},     out_op1, a);
        checkOutput({tag, ".op2"},     out_op2, b);
        checkOutput({tag, ".rd"},      {27'd0, out_rd}, rd);
        checkOutput({tag, ".rd_we"},   {31'd0, out_rd_we}, we);
        checkOutput({tag, ".illegal"}, {31'd0, out_illegal}, ill);
        checkOutput({tag, ".n_valid"}, {31'd0, out_valid0}, 32'd1);
        checkOutput({tag, ".n_op2"},   out_op20, b);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        out_ready = 1'b1;
        #12;
        checkOutput("rst.valid",   {31'd0, out_valid}, 32'd0);
        checkOutput("rst.alu_op",  {25'd0, out_alu_op}, ALU_ADD);
        checkOutput("rst.op1",     out_op1, 32'd0);
        checkOutput("rst.op2",     out_op2, 32'd0);
        checkOutput("rst.rd",      {27'd0, out_rd}, 32'd0);
        checkOutput("rst.rd_we",   {31'd0, out_rd_we}, 32'd0);
        checkOutput("rst.illegal", {31'd0, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd1);

        in_instr = 32'h002081B3;
        #1;
        checkOutput("add.rs1_addr", {27'd0, rs1_addr}, 32'd1);
        checkOutput("add.rs2_addr", {27'd0, rs2_addr}, 32'd2);
        applyStimulus(32'h002081B3, 32'h0, 32'd5, 32'd7);
        expectOut("add", ALU_ADD, 32'd5, 32'd7, 32'd3, 32'd1, 32'd0);
        applyStimulus(32'hFFF00093, 32'h4, 32'd0, 32'd0);
        expectOut("addi", ALU_ADD, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0);
        applyStimulus(32'h40435293, 32'h8, 32'hDEAD0000, 32'd99);
        expectOut("srai", ALU_SRA, 32'hDEAD0000, 32'd4, 32'd5, 32'd1, 32'd0);
        applyStimulus(32'h12345517, 32'h80, 32'd11, 32'd12);
        expectOut("auipc", ALU_ADD, 32'h80, 32'h12345000, 32'd10, 32'd1, 32'd0);
        applyStimulus(32'hABCDE037, 32'h84, 32'd11, 32'd12);
        expectOut("lui_x0", ALU_ADD, 32'd0, 32'hABCDE000, 32'd0, 32'd0, 32'd0);
        applyStimulus(32'h00000000, 32'h88, 32'd11, 32'd12);
        expectOut("ill_zero", ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1);
        applyStimulus(32'h0200B0B3, 32'h8C, 32'd11, 32'd12);
        expectOut("ill_f7", ALU_ADD, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1);
        applyStimulus(32'h402081B3, 32'h90, 32'd9, 32'd4);
        expectOut("sub", ALU_SUB, 32'd9, 32'd4, 32'd3, 32'd1, 32'd0);
        applyStimulus(32'h0062B233, 32'h94, 32'd1, 32'd2);
        expectOut("sltu", ALU_SLTU, 32'd1, 32'd2, 32'd4, 32'd1, 32'd0);
        applyStimulus(32'h00309093, 32'h98, 32'd6, 32'd0);
        expectOut("slli", ALU_SLL, 32'd6, 32'd3, 32'd1, 32'd1, 32'd0);
        applyStimulus(32'h02309093, 32'h9C, 32'd6, 32'd0);
        expectOut("slli_bad", ALU_ADD, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1);
        applyStimulus(32'h0F00F113, 32'hA0, 32'h1234, 32'd0);
        expectOut("andi", ALU_AND, 32'h1234, 32'hF0, 32'd2, 32'd1, 32'd0);
        applyStimulus(32'h0000A033, 32'hA4, 32'd3, 32'd8);
        expectOut("slt_x0", ALU_SLT, 32'd3, 32'd8, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("drain.valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: A goes to the output, B to the skid, C is held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        rs1_data  = 32'd1;
        rs2_data  = 32'd2;
        checkOutput("bp.ready_a", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp.ready_b", {31'd0, in_ready}, 32'd1);
        checkOutput("bp.n_ready", {31'd0, in_ready0}, 32'd0);
        in_instr = 32'h402081B3;
        rs1_data = 32'd10;
        rs2_data = 32'd3;
        @(posedge clk);
        #1;
        checkOutput("bp.ready_after_b", {31'd0, in_ready}, 32'd0);
        checkOutput("bp.hold_a_op1", out_op1, 32'd1);
        in_instr = 32'h0F00F113;
        rs1_data = 32'h55;
        rs2_data = 32'h66;
        @(posedge clk);
        #1;
        checkOutput("bp.ready_c_held", {31'd0, in_ready}, 32'd0);
        expectOut("bp.a_stall", ALU_ADD, 32'd1, 32'd2, 32'd3, 32'd1, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp.b.valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp.b.alu_op", {25'd0, out_alu_op}, ALU_SUB);
        checkOutput("bp.b.op1", out_op1, 32'd10);
        checkOutput("bp.b.op2", out_op2, 32'd3);
        checkOutput("bp.ready_refill", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp.c.valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp.c.alu_op", {25'd0, out_alu_op}, ALU_AND);
        checkOutput("bp.c.op1", out_op1, 32'h55);
        checkOutput("bp.c.op2", out_op2, 32'hF0);
        @(posedge clk);
        #1;
        checkOutput("bp.empty", {31'd0, out_valid}, 32'd0);

        // Reset asserted while output and skid are both full.
        out_ready = 1'b0;
        applyStimulus(32'h002081B3, 32'h0, 32'd1, 32'd2);
        applyStimulus(32'h402081B3, 32'h4, 32'd10, 32'd3);
        checkOutput("rs.skid_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rs.valid_now", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rs.no_stale", {31'd0, out_valid}, 32'd0);
            checkOutput("rs.in_ready", {31'd0, in_ready}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
